// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall / flush / bubble sequencing FSM.
// Optional perf counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_controller (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        brFlush,
  input  logic        brHold,
  input  logic        loadUse,
  input  logic        imemReady,
  input  logic        dmemReq,
  input  logic        dmemReady,
  output logic        enIF,
  output logic        enDEC,
  output logic        enEXE,
  output logic        enWB,
  output logic        bubbleDEC,
  output logic        bubbleEXE,
  output logic [1:0]  ctrlState
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    LOAD_STALL = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   memWait;
  logic   doFlush;

  assign memWait = dmemReq && !dmemReady;
  assign doFlush = brFlush || pend_q;

  // State and deferred-flush registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: strict request priority while running
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      RUN: begin
        if (memWait) begin
          state_d = MEM_WAIT;
        end else if (doFlush) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
        end else if (loadUse) begin
          state_d = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: state_d = RUN;
      LOAD_STALL: begin
        if (doFlush) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (brFlush) pend_d = 1'b1;
        if (dmemReady) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs: enables and bubbles from state and requests, reset wins
  always_comb begin
    enIF      = 1'b1;
    enDEC     = 1'b1;
    enEXE     = 1'b1;
    enWB      = 1'b1;
    bubbleDEC = 1'b0;
    bubbleEXE = 1'b0;
    unique case (state_q)
      RUN: begin
        if (memWait) begin
          enIF  = 1'b0;
          enDEC = 1'b0;
          enEXE = 1'b0;
          enWB  = 1'b0;
        end else if (doFlush) begin
          bubbleDEC = 1'b1;
          bubbleEXE = 1'b1;
        end else if (loadUse) begin
          enIF      = 1'b0;
          enDEC     = 1'b0;
          bubbleEXE = 1'b1;
        end else if (brHold || !imemReady) begin
          enIF      = 1'b0;
          bubbleDEC = 1'b1;
        end
      end
      FLUSH: begin
        enIF      = imemReady;
        bubbleDEC = !imemReady;
        bubbleEXE = 1'b1;
      end
      LOAD_STALL: begin
        if (doFlush) begin
          bubbleDEC = 1'b1;
          bubbleEXE = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmemReady) begin
          enIF  = 1'b0;
          enDEC = 1'b0;
          enEXE = 1'b0;
          enWB  = 1'b0;
        end
      end
      default: ;
    endcase
    if (!nReset) begin
      enIF      = 1'b0;
      enDEC     = 1'b0;
      enEXE     = 1'b0;
      enWB      = 1'b0;
      bubbleDEC = 1'b1;
      bubbleEXE = 1'b1;
    end
  end

  assign ctrlState = state_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic        flushEntry;

  assign flushEntry = (state_d == FLUSH) && (state_q != FLUSH);

  // Saturating counter next values
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!enIF && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    if (flushEntry && (flush_q != 32'hFFFF_FFFF)) flush_d = flush_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stallCount = stall_q;
  assign flushCount = flush_q;
`endif

endmodule
